dice_bank: RTL and testbench

Parametrised successor to the single electronic die. The block rolls N_DICE dice of FACES faces each, as long as the button is held. It enforces a minimum roll length and latches the final throw. It then flags the result with a one-cycle done pulse and a registered sum. It sits between the debounced push-button input and the display/score logic.

---
 rtl/dice_bank.sv | 120 ++++++++++++
 tb/tb_dice_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dice_bank.sv
// N_DICE odometer-style dice that roll while the button is held, with a minimum
// roll length, a latched final throw, a registered sum and a one-cycle done pulse.
module dice_bank #(
    parameter  int N_DICE   = 2,
    parameter  int FACES    = 6,
    parameter  int MIN_ROLL = 8,
    localparam int W        = $clog2(FACES + 1),
    localparam int SW       = $clog2(N_DICE * FACES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    output logic [N_DICE*W-1:0] throw,
    output logic [SW-1:0]       sum,
    output logic                rolling,
    output logic                done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ROLL = 1'b1;

    localparam int CNT_MAX = (MIN_ROLL == 0) ? 1 : MIN_ROLL;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MIN_C   = CW'(MIN_ROLL);
    localparam logic [CW-1:0] MAX_C   = CW'(CNT_MAX);
    localparam logic [W-1:0]  FACES_W = W'(FACES);
    localparam logic [W-1:0]  ONE_W   = W'(1);

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_DICE*W-1:0] throw_q, throw_d;
    logic [SW-1:0]       sum_q, sum_d;
    logic                done_q, done_d;

    logic                advance;
    logic                finish;
    logic [N_DICE-1:0]   carry;

    always_comb begin
        advance = ((state_q == IDLE) && button) ||
                  ((state_q == ROLL) && (button || (cnt_q < MIN_C)));
        finish  = (state_q == ROLL) && !button && (cnt_q >= MIN_C);
    end

    assign carry[0] = advance;

    // Each die steps when every lower die wraps on this edge; illegal values
    // snap back to 1 whether or not the dice are advancing.
    for (genvar gi = 0; gi < N_DICE; gi++) begin : g_die
        logic [W-1:0] die_v;
        logic         legal;
        logic         wrap;

        assign die_v = throw_q[gi*W +: W];
        assign legal = (die_v != '0) && (die_v <= FACES_W);
        assign wrap  = (die_v == FACES_W);

        always_comb begin
            if (!legal) begin
                throw_d[gi*W +: W] = ONE_W;
            end else if (carry[gi]) begin
                throw_d[gi*W +: W] = wrap ? ONE_W : die_v + ONE_W;
            end else begin
                throw_d[gi*W +: W] = die_v;
            end
        end

        if (gi < N_DICE - 1) begin : g_carry
            assign carry[gi+1] = carry[gi] & legal & wrap;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_DICE; i++) begin
            sum_d = sum_d + SW'(throw_d[i*W +: W]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (button) begin
                state_d = ROLL;
                cnt_d   = CW'(1);
            end
        end else if (finish) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
        end else if (cnt_q < MAX_C) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            throw_q <= {N_DICE{ONE_W}};
            sum_q   <= SW'(N_DICE);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            throw_q <= throw_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign throw   = throw_q;
    assign sum     = sum_q;
    assign rolling = (state_q == ROLL);
    assign done    = done_q;

endmodule

// File: tb/tb_dice_bank.sv
// Directed bench for dice_bank: three configurations driven one at a time
// against hand-computed die sequences.
module tb_dice_bank;

    logic clk;
    logic rst;
    logic ba, bb, bc;

    logic [5:0] ta, tb_t;
    logic [8:0] tc;
    logic [3:0] sa, sb, sc;
    logic       ra, rb, rc;
    logic       da, db, dc;

    int checks   = 0;
    int failures = 0;

    dice_bank #(.N_DICE(2), .FACES(6), .MIN_ROLL(0)) u_a (
        .clk(clk), .rst(rst), .button(ba),
        .throw(ta), .sum(sa), .rolling(ra), .done(da)
    );

    dice_bank #(.N_DICE(2), .FACES(6), .MIN_ROLL(4)) u_b (
        .clk(clk), .rst(rst), .button(bb),
        .throw(tb_t), .sum(sb), .rolling(rb), .done(db)
    );

    dice_bank #(.N_DICE(3), .FACES(4), .MIN_ROLL(0)) u_c (
        .clk(clk), .rst(rst), .button(bc),
        .throw(tc), .sum(sc), .rolling(rc), .done(dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [5:0] pk2(input int d0, input int d1);
        return {3'(d1), 3'(d0)};
    endfunction

    function automatic logic [8:0] pk3(input int d0, input int d1, input int d2);
        return {3'(d2), 3'(d1), 3'(d0)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int e0 [7] = '{2, 3, 4, 5, 6, 1, 2};
    int e1 [7] = '{1, 1, 1, 1, 1, 2, 2};
    int roll_cycles, done_cnt, done_edge;

    initial begin
        rst = 1'b0;
        ba  = 1'b0;
        bb  = 1'b0;
        bc  = 1'b0;

        // Reset takes effect between clock edges.
        #2 rst = 1'b1;
        #1;
        check("rst_throw", 32'(ta), 32'(pk2(1, 1)));
        check("rst_sum", 32'(sa), 2);
        check("rst_rolling", 32'(ra), 0);
        check("rst_done", 32'(da), 0);
        check("rst_throw_c", 32'(tc), 32'(pk3(1, 1, 1)));
        check("rst_sum_c", 32'(sc), 3);
        @(negedge clk);
        rst = 1'b0;

        // Odometer, no minimum length.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            ba = 1'b1;
            @(negedge clk);
            check($sformatf("odo_step%0d", k + 1), 32'(ta), 32'(pk2(e0[k], e1[k])));
        end
        check("odo_sum", 32'(sa), 4);
        check("odo_rolling", 32'(ra), 1);
        check("odo_done_early", 32'(da), 0);
        ba = 1'b0;
        @(negedge clk);
        check("odo_done", 32'(da), 1);
        check("odo_idle", 32'(ra), 0);
        check("odo_held", 32'(ta), 32'(pk2(2, 2)));
        @(negedge clk);
        check("odo_done_clear", 32'(da), 0);
        check("odo_held2", 32'(ta), 32'(pk2(2, 2)));
        check("odo_sum_held", 32'(sa), 4);

        // Full period of 36 advances.
        do_reset();
        ba = 1'b1;
        repeat (35) @(negedge clk);
        check("period35", 32'(ta), 32'(pk2(6, 6)));
        check("period35_sum", 32'(sa), 12);
        @(negedge clk);
        check("period36", 32'(ta), 32'(pk2(1, 1)));
        check("period36_sum", 32'(sa), 2);
        ba = 1'b0;
        repeat (2) @(negedge clk);

        // Minimum roll length from a single-edge press.
        do_reset();
        roll_cycles = 0;
        done_cnt    = 0;
        done_edge   = 0;
        for (int k = 1; k <= 8; k++) begin
            bb = (k == 1);
            @(negedge clk);
            if (rb) roll_cycles++;
            if (db) begin
                done_cnt++;
                done_edge = k;
            end
        end
        bb = 1'b0;
        check("min_throw", 32'(tb_t), 32'(pk2(5, 1)));
        check("min_sum", 32'(sb), 6);
        check("min_roll_cycles", 32'(roll_cycles), 4);
        check("min_done_cnt", 32'(done_cnt), 1);
        check("min_done_edge", 32'(done_edge), 5);

        // Re-press during the minimum-length extension.
        do_reset();
        done_cnt  = 0;
        done_edge = 0;
        for (int k = 1; k <= 10; k++) begin
            bb = (k == 1) || (k >= 3 && k <= 6);
            @(negedge clk);
            if (db) begin
                done_cnt++;
                done_edge = k;
            end
        end
        bb = 1'b0;
        check("repress_throw", 32'(tb_t), 32'(pk2(1, 2)));
        check("repress_sum", 32'(sb), 3);
        check("repress_done_cnt", 32'(done_cnt), 1);
        check("repress_done_edge", 32'(done_edge), 7);

        // Asynchronous reset in the middle of a roll.
        do_reset();
        bb = 1'b1;
        @(negedge clk);
        bb = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_pre", 32'(tb_t), 32'(pk2(4, 1)));
        #2 rst = 1'b1;
        #1;
        check("abort_throw", 32'(tb_t), 32'(pk2(1, 1)));
        check("abort_sum", 32'(sb), 2);
        check("abort_rolling", 32'(rb), 0);
        check("abort_done", 32'(db), 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (db) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 0);
        bb = 1'b1;
        @(negedge clk);
        bb = 1'b0;
        check("abort_restart", 32'(tb_t), 32'(pk2(2, 1)));
        check("abort_restart_roll", 32'(rb), 1);
        repeat (6) @(negedge clk);

        // Three-die wrap and illegal-value recovery.
        do_reset();
        force u_c.throw_q = pk3(4, 4, 4);
        #1 release u_c.throw_q;
        bc = 1'b1;
        @(negedge clk);
        bc = 1'b0;
        check("wrap3_throw", 32'(tc), 32'(pk3(1, 1, 1)));
        check("wrap3_sum", 32'(sc), 3);
        @(negedge clk);
        check("wrap3_done", 32'(dc), 1);
        force u_c.throw_q = pk3(1, 0, 1);
        #1 release u_c.throw_q;
        @(negedge clk);
        check("fix_zero_throw", 32'(tc), 32'(pk3(1, 1, 1)));
        check("fix_zero_sum", 32'(sc), 3);
        check("fix_zero_idle", 32'(rc), 0);
        force u_c.throw_q = pk3(2, 3, 7);
        #1 release u_c.throw_q;
        @(negedge clk);
        check("fix_big_throw", 32'(tc), 32'(pk3(2, 3, 1)));
        check("fix_big_sum", 32'(sc), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
